// File: rtl/ccff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_pkg
// Description : Shared types and helpers for the configuration-chain loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ccff_state_e;

    localparam int CCFF_WORD_W = 32;

    // Number of stream words needed to cover the whole chain (rounded up)
    function automatic int ccff_words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_deser.sv
`default_nettype none
// ============================================================================
// Module      : ccff_word_deser
// Description : Collects bits falling out of the chain tail into words and
//               presents each finished word on a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_word_deser
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic              last_i,
    input  logic              tail_i,
    input  logic              m_ready_i,
    output logic              m_valid_o,
    output logic [WORD_W-1:0] m_data_o,
    output logic              blocked_o
);

    localparam int              IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] merged;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              complete;

    // A capture finishes a word on its top bit or on the chain's final bit
    assign complete  = (idx_q == IDX_LAST) || last_i;
    // Finishing a word while the output register is still full must wait
    assign blocked_o = m_valid_q && complete;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;

    // Next-state for assembly buffer and output register
    always_comb begin
        merged        = word_q;
        merged[idx_q] = tail_i;
        word_d        = word_q;
        idx_d         = idx_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (capture_i) begin
            if (complete) begin
                // Buffer restarts from zero so a partial last word has clean upper bits
                m_data_d  = merged;
                m_valid_d = 1'b1;
                word_d    = '0;
                idx_d     = '0;
            end else begin
                word_d = merged;
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q    <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            word_q    <= word_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Configuration-chain writer: serialises bitstream words onto
//               ccff_head, gates the chain with a per-bit shift enable and
//               returns the bits leaving ccff_tail as readback words.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = CCFF_WORD_W,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS = ccff_words_per_chain(CHAIN_LEN, WORD_W);
    localparam int REM    = CHAIN_LEN % WORD_W;
    localparam int RW     = $clog2(WORD_W + 1);
    localparam int WC_W   = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  NWORDS_C    = WC_W'(NWORDS);
    localparam logic [WC_W-1:0]  LASTWORD_C  = WC_W'(NWORDS - 1);
    localparam logic [RW-1:0]    FULL_BITS_C = RW'(WORD_W);
    localparam logic [RW-1:0]    TAIL_BITS_C = (REM != 0) ? RW'(REM) : RW'(WORD_W);

    ccff_state_e       state_q;
    logic              busy_q, done_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]   words_q, words_d;
    logic [WORD_W-1:0] in_word_q, in_word_d;
    logic [RW-1:0]     in_rem_q, in_rem_d;

    logic              w_start;
    logic              w_shift;
    logic              w_accept;
    logic              w_last_bit;
    logic              w_blocked;
    logic [RW-1:0]     w_load_bits;

    // Control decoded purely from registered state (no s_valid/m_ready path)
    assign w_start     = (state_q == ST_IDLE) && start;
    assign w_last_bit  = (bit_cnt_q == LAST_C);
    assign w_shift     = (state_q == ST_SHIFT) && (in_rem_q != '0) && !w_blocked
                         && (bit_cnt_q < LEN_C);
    assign s_ready     = (state_q == ST_SHIFT)
                         && ((in_rem_q == '0) || (w_shift && (in_rem_q == RW'(1))))
                         && (words_q < NWORDS_C);
    assign w_accept    = s_valid && s_ready;
    // Only the low bits of a short final word ever reach the chain
    assign w_load_bits = (words_q == LASTWORD_C) ? TAIL_BITS_C : FULL_BITS_C;

    assign ccff_shift_en = w_shift;
    // Buffer LSB is a flop output, so head is stable across the whole shift cycle
    assign ccff_head     = in_word_q[0];
    assign busy          = busy_q;
    assign done          = done_q;

    // Serialiser and counter next-state; refill can land on the last-bit edge
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        words_d   = words_q;
        in_word_d = in_word_q;
        in_rem_d  = in_rem_q;
        if (w_start) begin
            bit_cnt_d = '0;
            words_d   = '0;
            in_word_d = '0;
            in_rem_d  = '0;
        end else begin
            if (w_shift) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                in_rem_d  = in_rem_q - 1'b1;
                in_word_d = (in_rem_q == RW'(1)) ? '0 : (in_word_q >> 1);
            end
            if (w_accept) begin
                in_word_d = s_data;
                in_rem_d  = w_load_bits;
                words_d   = words_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            bit_cnt_q <= '0;
            words_q   <= '0;
            in_word_q <= '0;
            in_rem_q  <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
            in_word_q <= in_word_d;
            in_rem_q  <= in_rem_d;
        end
    end

    // Load sequencer; DONE waits until the last readback word has been taken
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if ((bit_cnt_q == LEN_C) && !m_valid) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    ccff_word_deser #(
        .WORD_W(WORD_W)
    ) u_deser (
        .clk_i     (prog_clk),
        .rst_ni    (pReset),
        .clear_i   (w_start),
        .capture_i (w_shift),
        .last_i    (w_last_bit),
        .tail_i    (ccff_tail),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .blocked_o (w_blocked)
    );

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Scoreboard bench for the chain loader with behavioural chain
//               models (64-bit and 40-bit chains).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: 64-bit chain ----------------
    logic        a_rst_n, a_start, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [31:0] a_s_data, a_m_data;
    logic        a_head, a_tail, a_sh, a_busy, a_done;
    logic [63:0] a_chain = '0;

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut_a (
        .prog_clk(clk), .pReset(a_rst_n), .start(a_start),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .ccff_head(a_head), .ccff_tail(a_tail), .ccff_shift_en(a_sh),
        .busy(a_busy), .done(a_done)
    );

    assign a_tail = a_chain[63];
    always @(posedge clk) if (a_sh) a_chain <= {a_chain[62:0], a_head};

    // ---------------- instance B: 40-bit chain ----------------
    logic        b_rst_n, b_start, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_m_data;
    logic        b_head, b_tail, b_sh, b_busy, b_done;
    logic [39:0] b_chain = '0;

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut_b (
        .prog_clk(clk), .pReset(b_rst_n), .start(b_start),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .ccff_head(b_head), .ccff_tail(b_tail), .ccff_shift_en(b_sh),
        .busy(b_busy), .done(b_done)
    );

    assign b_tail = b_chain[39];
    always @(posedge clk) if (b_sh) b_chain <= {b_chain[38:0], b_head};

    // ---------------- counters ----------------
    int cyc = 0;
    int a_sh_tot = 0, a_acc_tot = 0, a_mark = 0, a_first_sh = 0, a_last_sh = 0;
    int b_sh_tot = 0, b_acc_tot = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_sh) begin
            if (a_sh_tot == a_mark) a_first_sh <= cyc;
            a_last_sh <= cyc;
            a_sh_tot  <= a_sh_tot + 1;
        end
        if (a_s_valid && a_s_ready) a_acc_tot <= a_acc_tot + 1;
        if (b_sh) b_sh_tot <= b_sh_tot + 1;
        if (b_s_valid && b_s_ready) b_acc_tot <= b_acc_tot + 1;
    end

    // ---------------- scoreboard ----------------
    int          checks = 0, errors = 0;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] a_exp, b_exp;

    // Handshake happens on the next posedge; m_data is stable at this negedge
    always @(negedge clk) begin
        if (a_m_valid && a_m_ready) begin
            checks++;
            if (a_q.size() == 0) begin
                errors++;
                $display("FAIL a_readback_unexpected: got 0x%08h, expected no word", a_m_data);
            end else begin
                a_exp = a_q.pop_front();
                if (a_m_data !== a_exp) begin
                    errors++;
                    $display("FAIL a_readback: got 0x%08h, expected 0x%08h", a_m_data, a_exp);
                end
            end
        end
        if (b_m_valid && b_m_ready) begin
            checks++;
            if (b_q.size() == 0) begin
                errors++;
                $display("FAIL b_readback_unexpected: got 0x%08h, expected no word", b_m_data);
            end else begin
                b_exp = b_q.pop_front();
                if (b_m_data !== b_exp) begin
                    errors++;
                    $display("FAIL b_readback: got 0x%08h, expected 0x%08h", b_m_data, b_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected event did not occur", name);
    endtask

    // Chain after a full load: stream bit 0 sits at the far end (index 63)
    function automatic logic [63:0] chain_exp(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] s;
        logic [63:0] r;
        s = {w1, w0};
        for (int i = 0; i < 64; i++) r[63 - i] = s[i];
        return r;
    endfunction

    task automatic a_send(input logic [31:0] w);
        int n;
        n = 0;
        a_s_valid = 1'b1;
        a_s_data  = w;
        while (!a_s_ready && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout_fail("a_send");
        @(negedge clk);
        a_s_valid = 1'b0;
    endtask

    task automatic a_load(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input int gap, input bit bp, input bit poke);
        int n;
        int acc0;
        a_mark = a_sh_tot;
        acc0   = a_acc_tot;
        a_q.push_back(e0);
        a_q.push_back(e1);
        a_m_ready = !bp;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_busy_after_start", a_busy, 1);
        a_send(w0);
        if (poke) begin
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        if (gap > 0) begin
            n = 0;
            while (!a_s_ready && n < 400) begin @(negedge clk); n++; end
            if (n >= 400) timeout_fail("a_gap_wait");
            @(negedge clk);
            for (int i = 0; i < gap; i++) begin
                chk("a_starve_shift_en", a_sh, 0);
                @(negedge clk);
            end
        end
        a_send(w1);
        if (bp) begin
            n = 0;
            while ((a_sh_tot - a_mark) < 63 && n < 400) begin @(negedge clk); n++; end
            if (n >= 400) timeout_fail("a_bp_wait");
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("a_bp_shift_en", a_sh, 0);
                chk("a_bp_mdata_stable", {a_m_valid, a_m_data}, {1'b1, e0});
            end
            chk("a_bp_shift_count", a_sh_tot - a_mark, 63);
            a_m_ready = 1'b1;
        end
        n = 0;
        while (!a_done && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout_fail("a_done_wait");
        chk("a_done_seen", {a_done, a_busy}, 2'b10);
        @(negedge clk);
        chk("a_done_one_cycle", {a_done, a_busy}, 0);
        chk("a_shift_count", a_sh_tot - a_mark, 64);
        chk("a_words_accepted", a_acc_tot - acc0, 2);
        if (gap == 0 && !bp) chk("a_shift_back_to_back", a_last_sh - a_first_sh + 1, 64);
    endtask

    task automatic b_load(input logic [31:0] e0, input logic [31:0] e1);
        int n;
        int sh0;
        int acc0;
        sh0  = b_sh_tot;
        acc0 = b_acc_tot;
        b_q.push_back(e0);
        b_q.push_back(e1);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        // Offer words continuously: a third word must never be taken
        b_s_valid = 1'b1;
        b_s_data  = 32'hFFFF_FFFF;
        n = 0;
        while (!b_done && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout_fail("b_done_wait");
        for (int i = 0; i < 3; i++) @(negedge clk);
        b_s_valid = 1'b0;
        chk("b_shift_count", b_sh_tot - sh0, 40);
        chk("b_words_accepted", b_acc_tot - acc0, 2);
    endtask

    initial begin
        int n;
        a_rst_n = 0; a_start = 0; a_s_valid = 0; a_s_data = '0; a_m_ready = 1;
        b_rst_n = 0; b_start = 0; b_s_valid = 0; b_s_data = '0; b_m_ready = 1;
        repeat (2) @(negedge clk);
        chk("a_reset_state", {a_s_ready, a_m_valid, a_sh, a_head, a_busy, a_done, a_m_data}, 0);
        chk("b_reset_state", {b_s_ready, b_m_valid, b_sh, b_head, b_busy, b_done, b_m_data}, 0);
        a_rst_n = 1;
        b_rst_n = 1;
        @(negedge clk);

        // Fresh chain reads back zeros; chain then holds the stream
        a_load(32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0, 32'h0, 0, 0, 0);
        chk("a_chain_after_load1", a_chain, chain_exp(32'hA5A5_A5A5, 32'h0000_FFFF));
        // Same data again: non-destructive readback, with a start pulse mid-load
        a_load(32'hA5A5_A5A5, 32'h0000_FFFF, 32'hA5A5_A5A5, 32'h0000_FFFF, 0, 0, 1);
        // Back-pressure on readback
        a_load(32'h1234_5678, 32'hCAFE_F00D, 32'hA5A5_A5A5, 32'h0000_FFFF, 0, 1, 0);
        // Input starvation between words
        a_load(32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h1234_5678, 32'hCAFE_F00D, 5, 0, 0);
        chk("a_chain_after_starve", a_chain, chain_exp(32'hDEAD_BEEF, 32'h0F0F_0F0F));

        // Reset in the middle of shifting
        a_mark = a_sh_tot;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_send(32'h5555_AAAA);
        n = 0;
        while ((a_sh_tot - a_mark) < 20 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout_fail("a_reset_wait");
        a_rst_n = 1'b0;
        #1;
        chk("a_midreset_outputs", {a_s_ready, a_m_valid, a_sh, a_head, a_busy, a_done, a_m_data}, 0);
        repeat (2) @(negedge clk);
        chk("a_midreset_hold", {a_s_ready, a_m_valid, a_sh, a_busy, a_done}, 0);
        a_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_idle_after_reset", {a_sh, a_busy, a_done, a_s_ready}, 0);

        // Partial final word on the 40-bit chain
        b_load(32'h0, 32'h0);
        b_load(32'hFFFF_FFFF, 32'h0000_00FF);

        repeat (4) @(negedge clk);
        chk("a_scoreboard_drained", a_q.size(), 0);
        chk("b_scoreboard_drained", b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer-side master for the configuration-chain (ccff) protocol used by every programmable tile.
- Accepts bitstream words on a valid/ready stream and serialises them onto `ccff_head` of the first tile in the chain.
- Emits a per-bit shift enable that gates the chain's programming clock.
- Captures the bits falling out of the last tile's `ccff_tail` and returns them as a readback word stream. Shifting a copy of the old bitstream back in gives a non-destructive readback.

Parameters:
- `WORD_W`, 32, width of bitstream and readback words.
- `CHAIN_LEN`, 1024, total number of configuration flip-flops in the chain (≥1).
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, bit-counter width (derived; do not override).

Ports:
- `prog_clk`  in  1  programming clock.
- `pReset`  in  1  asynchronous reset, active-low (0 = reset).
- `start`  in  1  single-cycle pulse; begins a full-chain load when idle.
- `s_valid`  in  1  bitstream word valid.
- `s_ready`  out  1  bitstream word accepted when `s_valid` && `s_ready`.
- `s_data`  in  `WORD_W`  bitstream word; bit 0 is shifted first.
- `m_valid`  out  1  readback word valid.
- `m_ready`  in  1  readback consumer ready.
- `m_data`  out  `WORD_W`  readback word; bit 0 is the first bit captured from the tail.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_tail`  in  1  serial data out of the chain end.
- `ccff_shift_en`  out  1  chain advances on the `prog_clk` rising edge where this is 1. Used by the external clock gate.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is reached.
- `done`  out  1  high while in DONE.

Behaviour:
- **Reset values:** `s_ready`, `m_valid`, `ccff_shift_en`, `ccff_head`, `busy`, `done` = 0; `m_data` = 0. All counters and buffers clear; state = IDLE.
- **States:**
  - IDLE: `start`=1 → SHIFT; clear bit counter, input buffer and readback buffer.
  - SHIFT: shift bits; when bit counter reaches `CHAIN_LEN` and the final readback word has been handed off (`m_valid`=0 after the last transfer) → DONE.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE is ignored.
- **Input buffer:** one `WORD_W` register plus bit index.
  - `s_ready` = (state==SHIFT) && (buffer empty || shift consumes the buffer's last valid bit this cycle) && (words accepted < ceil(`CHAIN_LEN`/`WORD_W`)).
  - Zero-bubble refill: a word consumed on its last bit can be replaced on the same edge.
- **Shift condition:** `ccff_shift_en` = (state==SHIFT) && input buffer holds ≥1 bit && readback assembly not blocked && bit counter < `CHAIN_LEN`.
  - Combinational from registered state only; no path from `s_valid` or `m_ready`.
- `ccff_head` = current buffer bit (bit index into the word), registered so it is stable for the whole cycle in which `ccff_shift_en`=1.
- **Capture:** on each shift edge, `ccff_tail` is sampled into readback position `bit_counter % WORD_W`. Latency from a bit entering `ccff_head` to its appearance on `ccff_tail` is `CHAIN_LEN` shifts. This is a property of the chain, not of this block.
- **Readback word completion:** a word completes when its `WORD_W`-th bit is captured, or on bit `CHAIN_LEN` for a partial final word.
  - On completion the word moves to the `m_data` register with `m_valid`=1, held stable until `m_ready`.
  - If a new word completes while `m_valid`=1 and `m_ready`=0, shifting stalls on its final bit (blocked) until the register frees.
  - Unused upper bits of a partial final word are 0.
- **Partial final bitstream word:** only its low (`CHAIN_LEN` mod `WORD_W`) bits are shifted; upper bits are discarded.
- **Exact shift count:** the number of `ccff_shift_en`=1 cycles per load is exactly `CHAIN_LEN`, independent of stalls.
- **Reset mid-operation:** immediate return to IDLE and `ccff_shift_en`=0. Chain contents are undefined; software must reload.
- `s_valid` in IDLE/DONE is never accepted.

Decomposition:
- Shared package `ccff_pkg`: state enum (IDLE, SHIFT, DONE); `CCFF_WORD_W` default; function computing words-per-chain, ceil(`CHAIN_LEN`/`WORD_W`).
- One sub-module `ccff_word_deser`: `WORD_W` shift-capture register with bit index, partial-flush and output valid/ready register. The top holds the FSM, input serialiser and counters.

Test Plan:
- **Full load, no stalls.** `CHAIN_LEN`=64, `WORD_W`=32, chain model = 64-FF shift register preloaded 0. Stream 0xA5A5A5A5, 0x0000FFFF with `m_ready`=1 → 64 shift cycles back-to-back, readback 0x00000000, 0x00000000, `done` pulse; chain then holds the stream, first bit at the far end.
- **Non-destructive readback.** Reload with the same data as the first load → readback words equal 0xA5A5A5A5, 0x0000FFFF, in order.
- **Partial word.** `CHAIN_LEN`=40, `WORD_W`=32, input 0xFFFFFFFF, 0xFFFFFFFF → exactly 40 shifts; second readback word has bits [31:8]=0; only 2 words accepted.
- **Back-pressure.** Hold `m_ready`=0 after the first readback word → `ccff_shift_en` drops after the 64th capture attempt blocks (shift count stays 63 until released), `m_data` stable. Release → final shift and DONE.
- **Input starvation.** Deassert `s_valid` for 5 cycles mid-word → `ccff_shift_en`=0 during the gap; total shift count still 64; chain contents correct.
- **Reset and ignored start.** Assert `pReset`=0 at shift 20 → all outputs at reset values next sample, state IDLE. `start` pulsed while `busy` → no effect on counters.
